// File: rtl/mem_unit_pkg.sv
// Shared constants and types for the memory access unit: FSM encoding,
// access size codes and the registered bus request payload.
package mem_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned STATE_W     = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned F3_SIGN_BIT = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } bus_req_t;

  // Size code 11 is reserved; halves need even, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, alignment
// check on the request side and lane select/extension on the load side.
module mem_align
  import mem_unit_pkg::*;
(
  input  logic [1:0]      sz,
  input  logic [1:0]      lo,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic            misaligned,
  input  logic [2:0]      ld_f3,
  input  logic [1:0]      ld_lo,
  input  logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] ld_ext
);

  logic [15:0] lane;
  logic        sx;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = is_misaligned(sz, lo);
    case (sz)
      SZ_BYTE: begin
        be        = 4'(4'b0001 << lo);
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'(4'b0011 << lo);
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by funct3 sign bit.
  always_comb begin
    lane = 16'(ld_data >> {ld_lo, 3'b000});
    sx   = ~ld_f3[F3_SIGN_BIT];
    case (ld_f3[1:0])
      SZ_BYTE: ld_ext = {{24{sx & lane[7]}}, lane[7:0]};
      SZ_HALF: ld_ext = {{16{sx & lane[15]}}, lane[15:0]};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Multicycle load/store unit: latches a control request, runs one strobe/ack
// bus transaction with timeout, and reports completion or fault for one cycle.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      f3,
  output logic            mem_complete,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            bus_error,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  output logic            bus_read,
  output logic            bus_write,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lo_q, lo_d;
  bus_req_t           bus_q, bus_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic               cpl_q, cpl_d, mis_q, mis_d, err_q, err_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;

  logic [3:0]         al_be;
  logic [XLEN-1:0]    al_wdata, ld_ext;
  logic               al_mis;

  mem_align u_align (
    .sz         (f3[1:0]),
    .lo         (addr[1:0]),
    .wdata      (wdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .misaligned (al_mis),
    .ld_f3      (f3_q),
    .ld_lo      (lo_q),
    .ld_data    (bus_rdata),
    .ld_ext     (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    bus_d   = bus_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    cpl_d   = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          f3_d = f3;
          lo_d = addr[1:0];
          if (al_mis) begin
            state_d = ST_DONE;
            cpl_d   = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d     = ST_BUSY;
            cnt_d       = '0;
            bus_d.addr  = {addr[XLEN-1:2], 2'b00};
            bus_d.wdata = al_wdata;
            bus_d.be    = al_be;
            rd_d        = mem_read;
            wr_d        = ~mem_read;
          end
        end
      end
      ST_BUSY: begin
        // Ack takes precedence over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d = ST_DONE;
          rdata_d = ld_ext;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cpl_d   = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cpl_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      bus_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      cpl_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      bus_q   <= bus_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      cpl_q   <= cpl_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign mem_complete = cpl_q;
  assign rdata        = rdata_q;
  assign misaligned   = mis_q;
  assign bus_error    = err_q;
  assign bus_addr     = bus_q.addr;
  assign bus_wdata    = bus_q.wdata;
  assign bus_be       = bus_q.be;
  assign bus_read     = rd_q;
  assign bus_write    = wr_q;

endmodule
